// File: rtl/capture_pkg.sv
// Shared types and defaults for the scope capture sequencer.
package capture_pkg;

  localparam int DATA_W_DEF = 12;
  localparam int ADDR_W_DEF = 10;

  // Default trigger level for top-level tie-off.
  localparam logic [11:0] LEVEL_DEF = 12'h5DC;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PRETRIG = 3'd1,
    ST_ARMED   = 3'd2,
    ST_POST    = 3'd3,
    ST_XFER    = 3'd4
  } state_t;

endpackage

// File: rtl/level_crossing_detector.sv
// Slope-qualified level crossing between the previous valid sample and the current one.
module level_crossing_detector #(
  parameter int DATA_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              valid,
  input  logic [DATA_W-1:0] data,
  input  logic [DATA_W-1:0] level,
  input  logic              rising,
  input  logic              enable,
  output logic              hit
);

  logic [DATA_W-1:0] prev;
  logic              prev_valid;
  logic              crossed;

  always_ff @(posedge clk) begin
    if (reset) begin
      prev       <= '0;
      prev_valid <= 1'b0;
    end else if (clear) begin
      prev_valid <= 1'b0;
    end else if (valid) begin
      prev       <= data;
      prev_valid <= 1'b1;
    end
  end

  // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
  always_comb begin
    crossed = 1'b0;
    if (rising) crossed = (prev < level) && (data >= level);
    else        crossed = (prev > level) && (data <= level);
    hit = enable && valid && prev_valid && crossed;
  end

endmodule

// File: rtl/capture_sequencer.sv
// Acquisition controller: circular pre-trigger capture, level trigger, post fill, readout handoff.
import capture_pkg::*;

module capture_sequencer #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_arm,
  input  logic              i_single,
  input  logic [DATA_W-1:0] i_level,
  input  logic              i_rising,
  input  logic [ADDR_W-1:0] i_pretrig,
  input  logic              i_response_valid,
  input  logic [DATA_W-1:0] i_sample_data,
  input  logic              i_transfer_done,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [DATA_W-1:0] o_wr_data,
  output logic [ADDR_W-1:0] o_trig_addr,
  output logic              o_trigger,
  output logic              o_transfer_req,
  output logic              o_busy
);

  state_t            state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] pre_cnt;
  logic [ADDR_W-1:0] post_cnt;
  logic [ADDR_W-1:0] post_load;
  logic [ADDR_W-1:0] cfg_pretrig;
  logic [DATA_W-1:0] cfg_level;
  logic              cfg_single;
  logic              cfg_rising;
  logic              sample_ok;
  logic              start_go;
  logic              hit;
  state_t            start_state;

  assign sample_ok   = i_response_valid && (state inside {ST_PRETRIG, ST_ARMED, ST_POST});
  assign start_go    = ((state == ST_IDLE) && i_arm) ||
                       ((state == ST_XFER) && i_transfer_done && !cfg_single);
  assign start_state = (i_pretrig == '0) ? ST_ARMED : ST_PRETRIG;
  // DEPTH-1-pretrig; the port width already bounds pretrig to DEPTH-1.
  assign post_load   = {ADDR_W{1'b1}} - cfg_pretrig;

  level_crossing_detector #(.DATA_W(DATA_W)) u_detect (
    .clk    (i_clk),
    .reset  (i_reset),
    .clear  (start_go),
    .valid  (sample_ok),
    .data   (i_sample_data),
    .level  (cfg_level),
    .rising (cfg_rising),
    .enable (state == ST_ARMED),
    .hit    (hit)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every branch sees pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state          <= ST_IDLE;
      wr_ptr         <= '0;
      pre_cnt        <= '0;
      post_cnt       <= '0;
      cfg_pretrig    <= '0;
      cfg_level      <= '0;
      cfg_single     <= 1'b0;
      cfg_rising     <= 1'b0;
      o_wr_en        <= 1'b0;
      o_wr_addr      <= '0;
      o_wr_data      <= '0;
      o_trig_addr    <= '0;
      o_trigger      <= 1'b0;
      o_transfer_req <= 1'b0;
      o_busy         <= 1'b0;
    end else begin
      o_wr_en   <= sample_ok;
      o_trigger <= 1'b0;
      if (sample_ok) begin
        o_wr_addr <= wr_ptr;
        o_wr_data <= i_sample_data;
        wr_ptr    <= wr_ptr + 1'b1;
      end

      if (start_go) begin
        cfg_single  <= i_single;
        cfg_level   <= i_level;
        cfg_rising  <= i_rising;
        cfg_pretrig <= i_pretrig;
        pre_cnt     <= '0;
      end

      case (state)
        ST_IDLE: begin
          if (i_arm) begin
            state  <= start_state;
            o_busy <= 1'b1;
          end
        end
        ST_PRETRIG: begin
          if (i_response_valid) begin
            if (pre_cnt == cfg_pretrig - 1'b1) state <= ST_ARMED;
            else                               pre_cnt <= pre_cnt + 1'b1;
          end
        end
        ST_ARMED: begin
          if (hit) begin
            o_trigger   <= 1'b1;
            o_trig_addr <= wr_ptr;
            post_cnt    <= post_load;
            if (post_load == '0) begin
              state          <= ST_XFER;
              o_transfer_req <= 1'b1;
            end else begin
              state <= ST_POST;
            end
          end
        end
        ST_POST: begin
          if (i_response_valid) begin
            if (post_cnt == 1) begin
              state          <= ST_XFER;
              o_transfer_req <= 1'b1;
            end
            post_cnt <= post_cnt - 1'b1;
          end
        end
        ST_XFER: begin
          if (i_transfer_done) begin
            o_transfer_req <= 1'b0;
            if (cfg_single) begin
              state  <= ST_IDLE;
              o_busy <= 1'b0;
            end else begin
              state <= start_state;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_capture_sequencer.sv
// Directed bench for capture_sequencer with DEPTH=16.
module tb_capture_sequencer;
  import capture_pkg::*;

  localparam int DW = 12;
  localparam int AW = 4;

  logic          i_clk = 1'b0;
  logic          i_reset = 1'b1;
  logic          i_arm = 1'b0;
  logic          i_single = 1'b1;
  logic [DW-1:0] i_level = 12'd100;
  logic          i_rising = 1'b1;
  logic [AW-1:0] i_pretrig = 4'd4;
  logic          i_response_valid = 1'b0;
  logic [DW-1:0] i_sample_data = '0;
  logic          i_transfer_done = 1'b0;
  logic          o_wr_en;
  logic [AW-1:0] o_wr_addr;
  logic [DW-1:0] o_wr_data;
  logic [AW-1:0] o_trig_addr;
  logic          o_trigger;
  logic          o_transfer_req;
  logic          o_busy;

  int total = 0;
  int bad = 0;
  logic [AW-1:0] exp_ptr = '0;

  capture_sequencer #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .i_clk            (i_clk),
    .i_reset          (i_reset),
    .i_arm            (i_arm),
    .i_single         (i_single),
    .i_level          (i_level),
    .i_rising         (i_rising),
    .i_pretrig        (i_pretrig),
    .i_response_valid (i_response_valid),
    .i_sample_data    (i_sample_data),
    .i_transfer_done  (i_transfer_done),
    .o_wr_en          (o_wr_en),
    .o_wr_addr        (o_wr_addr),
    .o_wr_data        (o_wr_data),
    .o_trig_addr      (o_trig_addr),
    .o_trigger        (o_trigger),
    .o_transfer_req   (o_transfer_req),
    .o_busy           (o_busy)
  );

  always #5 i_clk = ~i_clk;

  // One clock: present inputs, let the edge pass, observe 1 time unit later.
  task automatic step(input logic v, input logic [DW-1:0] d);
    i_response_valid = v;
    i_sample_data    = d;
    @(posedge i_clk);
    #1;
    i_response_valid = 1'b0;
    i_arm            = 1'b0;
    i_transfer_done  = 1'b0;
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    step(1'b0, '0);
    i_reset = 1'b0;
    exp_ptr = '0;
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    step(1'b1, 12'd77);
    step(1'b0, '0);
    i_reset = 1'b0;
    exp_ptr = '0;
    total++;
    if ({o_wr_en, o_wr_addr, o_wr_data, o_trig_addr, o_trigger, o_transfer_req, o_busy} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got wr_en=%0b addr=%0d data=%0d taddr=%0d trig=%0b req=%0b busy=%0b want all 0",
               o_wr_en, o_wr_addr, o_wr_data, o_trig_addr, o_trigger, o_transfer_req, o_busy);
    end
    total++;
    if (dut.state !== ST_IDLE) begin
      bad++; $display("FAIL reset_state got=%0d want=%0d", dut.state, ST_IDLE);
    end
  endtask

  task automatic test_ramp();
    int nwr;
    i_single = 1'b1; i_level = 12'd100; i_rising = 1'b1; i_pretrig = 4'd4;
    i_arm = 1'b1;
    step(1'b0, '0);
    total++;
    if (o_busy !== 1'b1 || dut.state !== ST_PRETRIG || o_wr_en !== 1'b0) begin
      bad++; $display("FAIL ramp_arm got busy=%0b state=%0d wr_en=%0b want 1/%0d/0", o_busy, dut.state, o_wr_en, ST_PRETRIG);
    end
    for (int i = 0; i <= 10; i++) begin
      step(1'b1, 12'(i * 10));
      total++;
      if ({o_wr_en, o_wr_addr, o_wr_data, o_trigger} !== {1'b1, exp_ptr, 12'(i * 10), (i == 10)}) begin
        bad++; $display("FAIL ramp_pre_write i=%0d got en=%0b addr=%0d data=%0d trig=%0b want 1/%0d/%0d/%0b",
                        i, o_wr_en, o_wr_addr, o_wr_data, o_trigger, exp_ptr, i * 10, i == 10);
      end
      if (i == 3) begin
        total++;
        if (dut.state !== ST_ARMED) begin
          bad++; $display("FAIL ramp_to_armed got=%0d want=%0d", dut.state, ST_ARMED);
        end
      end
      exp_ptr++;
    end
    total++;
    if (o_trig_addr !== 4'd10) begin
      bad++; $display("FAIL ramp_trig_addr got=%0d want=10", o_trig_addr);
    end
    nwr = 1;
    for (int i = 11; i <= 21; i++) begin
      step(1'b1, 12'(i * 10));
      if (o_wr_en === 1'b1) nwr++;
      total++;
      if ({o_wr_addr, o_transfer_req, o_trigger} !== {exp_ptr, (i == 21), 1'b0}) begin
        bad++; $display("FAIL ramp_post i=%0d got addr=%0d req=%0b trig=%0b want %0d/%0b/0",
                        i, o_wr_addr, o_transfer_req, o_trigger, exp_ptr, i == 21);
      end
      exp_ptr++;
    end
    total++;
    if (nwr != 12) begin
      bad++; $display("FAIL ramp_write_count got=%0d want=12", nwr);
    end
    step(1'b1, 12'd500);
    total++;
    if (o_wr_en !== 1'b0 || o_transfer_req !== 1'b1) begin
      bad++; $display("FAIL ramp_xfer_hold got wr_en=%0b req=%0b want 0/1", o_wr_en, o_transfer_req);
    end
    i_transfer_done = 1'b1;
    step(1'b0, '0);
    total++;
    if (o_busy !== 1'b0 || o_transfer_req !== 1'b0 || dut.state !== ST_IDLE) begin
      bad++; $display("FAIL ramp_done got busy=%0b req=%0b state=%0d want 0/0/%0d", o_busy, o_transfer_req, dut.state, ST_IDLE);
    end
  endtask

  task automatic test_flat();
    logic saw_wrap;
    logic [AW-1:0] last_addr;
    saw_wrap = 1'b0;
    last_addr = '0;
    i_pretrig = 4'd4; i_rising = 1'b1; i_level = 12'd100;
    i_arm = 1'b1;
    step(1'b0, '0);
    for (int i = 0; i < 24; i++) begin
      step(1'b1, 12'd150);
      total++;
      if ({o_wr_en, o_wr_addr, o_wr_data, o_trigger} !== {1'b1, exp_ptr, 12'd150, 1'b0}) begin
        bad++; $display("FAIL flat_write i=%0d got en=%0b addr=%0d data=%0d trig=%0b want 1/%0d/150/0",
                        i, o_wr_en, o_wr_addr, o_wr_data, o_trigger, exp_ptr);
      end
      if (i > 0 && last_addr == 4'd15 && o_wr_addr == 4'd0) saw_wrap = 1'b1;
      last_addr = o_wr_addr;
      exp_ptr++;
    end
    total++;
    if (o_busy !== 1'b1 || o_transfer_req !== 1'b0 || saw_wrap !== 1'b1) begin
      bad++; $display("FAIL flat_status got busy=%0b req=%0b wrap=%0b want 1/0/1", o_busy, o_transfer_req, saw_wrap);
    end
    do_reset();
  endtask

  task automatic test_falling();
    i_rising = 1'b0; i_pretrig = 4'd1; i_level = 12'd100;
    i_arm = 1'b1;
    step(1'b0, '0);
    step(1'b1, 12'd200);
    step(1'b1, 12'd150);
    total++;
    if (o_trigger !== 1'b0) begin
      bad++; $display("FAIL fall_150 got trig=%0b want 0", o_trigger);
    end
    step(1'b1, 12'd100);
    total++;
    if (o_trigger !== 1'b1 || o_trig_addr !== 4'd2 || o_wr_addr !== 4'd2) begin
      bad++; $display("FAIL fall_100 got trig=%0b taddr=%0d addr=%0d want 1/2/2", o_trigger, o_trig_addr, o_wr_addr);
    end
    do_reset();
    i_arm = 1'b1;
    step(1'b0, '0);
    step(1'b1, 12'd200);
    step(1'b1, 12'd150);
    step(1'b1, 12'd101);
    total++;
    if (o_trigger !== 1'b0 || dut.state !== ST_ARMED) begin
      bad++; $display("FAIL fall_101 got trig=%0b state=%0d want 0/%0d", o_trigger, dut.state, ST_ARMED);
    end
    do_reset();
  endtask

  task automatic test_rearm();
    i_single = 1'b0; i_rising = 1'b1; i_pretrig = 4'd2; i_level = 12'd100;
    i_arm = 1'b1;
    step(1'b0, '0);
    step(1'b1, 12'd0);
    step(1'b1, 12'd0);
    exp_ptr = exp_ptr + 4'd2;
    i_arm = 1'b1;
    step(1'b0, '0);
    i_transfer_done = 1'b1;
    step(1'b0, '0);
    total++;
    if (dut.state !== ST_ARMED || o_transfer_req !== 1'b0) begin
      bad++; $display("FAIL rearm_ignore got state=%0d req=%0b want %0d/0", dut.state, o_transfer_req, ST_ARMED);
    end
    step(1'b1, 12'd50);
    step(1'b1, 12'd100);
    total++;
    if (o_trigger !== 1'b1 || o_trig_addr !== 4'd3) begin
      bad++; $display("FAIL rearm_trig got trig=%0b taddr=%0d want 1/3", o_trigger, o_trig_addr);
    end
    exp_ptr = exp_ptr + 4'd2;
    for (int i = 0; i < 13; i++) begin
      step(1'b1, 12'd7);
      exp_ptr++;
    end
    total++;
    if (o_transfer_req !== 1'b1 || dut.state !== ST_XFER) begin
      bad++; $display("FAIL rearm_xfer got req=%0b state=%0d want 1/%0d", o_transfer_req, dut.state, ST_XFER);
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 12'd9);
      total++;
      if (o_wr_en !== 1'b0) begin
        bad++; $display("FAIL rearm_xfer_drop i=%0d got wr_en=%0b want 0", i, o_wr_en);
      end
    end
    i_transfer_done = 1'b1;
    step(1'b0, '0);
    total++;
    if (dut.state !== ST_PRETRIG || o_busy !== 1'b1 || o_transfer_req !== 1'b0) begin
      bad++; $display("FAIL rearm_restart got state=%0d busy=%0b req=%0b want %0d/1/0", dut.state, o_busy, o_transfer_req, ST_PRETRIG);
    end
    step(1'b1, 12'd33);
    total++;
    if ({o_wr_en, o_wr_addr, o_wr_data} !== {1'b1, exp_ptr, 12'd33}) begin
      bad++; $display("FAIL rearm_continue got en=%0b addr=%0d data=%0d want 1/%0d/33", o_wr_en, o_wr_addr, o_wr_data, exp_ptr);
    end
    do_reset();
    i_single = 1'b1;
  endtask

  task automatic test_reset_in_post();
    i_single = 1'b1; i_rising = 1'b1; i_pretrig = 4'd4; i_level = 12'd100;
    for (int pass = 0; pass < 2; pass++) begin
      i_arm = 1'b1;
      step(1'b0, '0);
      for (int i = 0; i < 4; i++) step(1'b1, 12'd0);
      step(1'b1, 12'd50);
      step(1'b1, 12'd100);
      total++;
      if (o_trigger !== 1'b1 || o_trig_addr !== 4'd5) begin
        bad++; $display("FAIL rst_post_trig pass=%0d got trig=%0b taddr=%0d want 1/5", pass, o_trigger, o_trig_addr);
      end
      if (pass == 0) begin
        for (int i = 0; i < 3; i++) step(1'b1, 12'd120);
        i_reset = 1'b1;
        step(1'b1, 12'd333);
        i_reset = 1'b0;
        total++;
        if ({o_wr_en, o_wr_addr, o_wr_data, o_trig_addr, o_trigger, o_transfer_req, o_busy} !== '0 ||
            dut.state !== ST_IDLE) begin
          bad++; $display("FAIL rst_post_clear got en=%0b addr=%0d data=%0d taddr=%0d trig=%0b req=%0b busy=%0b state=%0d want all 0",
                          o_wr_en, o_wr_addr, o_wr_data, o_trig_addr, o_trigger, o_transfer_req, o_busy, dut.state);
        end
      end
    end
    do_reset();
  endtask

  task automatic test_pretrig_edges();
    i_single = 1'b1; i_rising = 1'b0; i_pretrig = 4'd15; i_level = 12'd100;
    i_arm = 1'b1;
    step(1'b0, '0);
    for (int i = 0; i < 15; i++) step(1'b1, 12'd200);
    total++;
    if (dut.state !== ST_ARMED || o_wr_addr !== 4'd14) begin
      bad++; $display("FAIL pre15_armed got state=%0d addr=%0d want %0d/14", dut.state, o_wr_addr, ST_ARMED);
    end
    step(1'b1, 12'd50);
    total++;
    if (o_trigger !== 1'b1 || o_transfer_req !== 1'b1 || o_trig_addr !== 4'd15 || dut.state !== ST_XFER) begin
      bad++; $display("FAIL pre15_direct_xfer got trig=%0b req=%0b taddr=%0d state=%0d want 1/1/15/%0d",
                      o_trigger, o_transfer_req, o_trig_addr, dut.state, ST_XFER);
    end
    i_transfer_done = 1'b1;
    step(1'b0, '0);
    i_rising = 1'b1; i_pretrig = 4'd0;
    i_arm = 1'b1;
    step(1'b0, '0);
    total++;
    if (dut.state !== ST_ARMED || o_busy !== 1'b1) begin
      bad++; $display("FAIL pre0_armed got state=%0d busy=%0b want %0d/1", dut.state, o_busy, ST_ARMED);
    end
    step(1'b1, 12'd150);
    total++;
    if (o_trigger !== 1'b0 || o_wr_en !== 1'b1 || o_wr_addr !== 4'd0) begin
      bad++; $display("FAIL pre0_first got trig=%0b en=%0b addr=%0d want 0/1/0", o_trigger, o_wr_en, o_wr_addr);
    end
    step(1'b1, 12'd50);
    step(1'b1, 12'd150);
    total++;
    if (o_trigger !== 1'b1 || o_trig_addr !== 4'd2 || dut.state !== ST_POST) begin
      bad++; $display("FAIL pre0_trig got trig=%0b taddr=%0d state=%0d want 1/2/%0d", o_trigger, o_trig_addr, dut.state, ST_POST);
    end
    do_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ramp();
    test_flat();
    test_falling();
    test_rearm();
    test_reset_in_post();
    test_pretrig_edges();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
